// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage of the pipelined RV32I core.
//
// Issues in-order word requests to instruction memory. A small queue holds
// the returned words together with their addresses. One instr/PC pair per
// cycle is presented to decode. The stage honours the decode stall (hazard)
// and the execute-stage redirect (pcWriteEnable/pcWriteData). A redirect
// raises a one-cycle flush pulse that squashes wrong-path work downstream.
//
// Parameters:
//   RESET_PC  fetch address after reset
//   DEPTH     queue entries (power of two, >= 2); it also caps the number of
//             in-flight requests plus queued entries
//   NOP       bubble instruction (addi x0,x0,0)
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   imemReq        out  request valid (combinational credit check)
//   imemAddr       out  request word address (fetch PC)
//   imemReady      in   memory accepts the request this cycle
//   imemRespValid  in   response valid; responses return in order
//   imemRespData   in   response instruction word
//   pcWriteData    in   redirect target
//   pcWriteEnable  in   redirect strobe
//   hazard         in   decode stall; the IF/ID registers hold
//   instr          out  IF/ID instruction register
//   PC             out  IF/ID address register
//   flush          out  registered one-cycle squash pulse
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic [31:0] pcWriteData,
    input  logic        pcWriteEnable,
    input  logic        hazard,
    output logic [31:0] instr,
    output logic [31:0] PC,
    output logic        flush
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // Architectural state
    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [31:0]   q_pc_r   [DEPTH];
    logic [31:0]   q_data_r [DEPTH];
    logic [31:0]   instr_r;
    logic [31:0]   pc_r;
    logic          flush_r;

    // Next-state and handshake signals
    logic          credit_s;
    logic          req_s;
    logic          accept_s;
    logic          resp_s;
    logic          tagged_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   fetch_pc_nx_s;
    logic [31:0]   resp_pc_nx_s;
    logic [CW-1:0] outstanding_nx_s;
    logic [CW-1:0] discard_nx_s;
    logic [CW-1:0] count_nx_s;
    logic [PW-1:0] rd_ptr_nx_s;
    logic [PW-1:0] wr_ptr_nx_s;
    logic [31:0]   instr_nx_s;
    logic [31:0]   pc_nx_s;
    logic          flush_nx_s;

    // Request credit and response qualification
    always_comb begin
        // Every in-flight request must have a queue slot waiting for it.
        credit_s = (({1'b0, outstanding_r} + {1'b0, count_r}) < DEPTH_C);
        req_s    = credit_s & ~pcWriteEnable;
        accept_s = req_s & imemReady;
        // A response with nothing outstanding belongs to a request issued
        // before reset and is ignored completely.
        resp_s   = imemRespValid & (outstanding_r != CNT_ZERO);
        tagged_s = resp_s & (discard_r == CNT_ZERO);
    end

    // Next-state computation: redirect first, then fetch/response/output
    always_comb begin
        fetch_pc_nx_s    = fetch_pc_r;
        resp_pc_nx_s     = resp_pc_r;
        outstanding_nx_s = outstanding_r;
        discard_nx_s     = discard_r;
        count_nx_s       = count_r;
        rd_ptr_nx_s      = rd_ptr_r;
        wr_ptr_nx_s      = wr_ptr_r;
        instr_nx_s       = instr_r;
        pc_nx_s          = pc_r;
        flush_nx_s       = 1'b0;
        bypass_s         = 1'b0;
        push_s           = 1'b0;
        pop_s            = 1'b0;

        if (pcWriteEnable) begin
            // Requests still in flight come back on the wrong path; count
            // them so they are dropped. A response arriving now is dropped
            // directly and no longer counts.
            fetch_pc_nx_s    = pcWriteData;
            resp_pc_nx_s     = pcWriteData;
            outstanding_nx_s = outstanding_r - (resp_s ? CNT_ONE : CNT_ZERO);
            discard_nx_s     = outstanding_r - (resp_s ? CNT_ONE : CNT_ZERO);
            count_nx_s       = CNT_ZERO;
            rd_ptr_nx_s      = PTR_ZERO;
            wr_ptr_nx_s      = PTR_ZERO;
            instr_nx_s       = NOP;
            pc_nx_s          = pc_r;
            flush_nx_s       = 1'b1;
        end else begin
            if (accept_s) begin
                fetch_pc_nx_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_nx_s = fetch_pc_r;
            end

            outstanding_nx_s = outstanding_r
                             + (accept_s ? CNT_ONE : CNT_ZERO)
                             - (resp_s ? CNT_ONE : CNT_ZERO);

            if (resp_s && (discard_r != CNT_ZERO)) begin
                discard_nx_s = discard_r - CNT_ONE;
            end else begin
                discard_nx_s = discard_r;
            end

            if (tagged_s) begin
                resp_pc_nx_s = resp_pc_r + 32'd4;
            end else begin
                resp_pc_nx_s = resp_pc_r;
            end

            // Output stage: the queue head has priority, so words already
            // buffered always leave before a newer response.
            if (hazard) begin
                instr_nx_s = instr_r;
                pc_nx_s    = pc_r;
            end else if (count_r != CNT_ZERO) begin
                pop_s      = 1'b1;
                instr_nx_s = q_data_r[rd_ptr_r];
                pc_nx_s    = q_pc_r[rd_ptr_r];
            end else if (tagged_s) begin
                bypass_s   = 1'b1;
                instr_nx_s = imemRespData;
                pc_nx_s    = resp_pc_r;
            end else begin
                instr_nx_s = NOP;
                pc_nx_s    = pc_r;
            end

            push_s     = tagged_s & ~bypass_s;
            count_nx_s = count_r
                       + (push_s ? CNT_ONE : CNT_ZERO)
                       - (pop_s ? CNT_ONE : CNT_ZERO);

            if (push_s) begin
                wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nx_s = wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nx_s = rd_ptr_r;
            end
        end
    end

    // Control state and IF/ID output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
            count_r       <= CNT_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            instr_r       <= NOP;
            pc_r          <= RESET_PC;
            flush_r       <= 1'b0;
        end else begin
            fetch_pc_r    <= fetch_pc_nx_s;
            resp_pc_r     <= resp_pc_nx_s;
            outstanding_r <= outstanding_nx_s;
            discard_r     <= discard_nx_s;
            count_r       <= count_nx_s;
            rd_ptr_r      <= rd_ptr_nx_s;
            wr_ptr_r      <= wr_ptr_nx_s;
            instr_r       <= instr_nx_s;
            pc_r          <= pc_nx_s;
            flush_r       <= flush_nx_s;
        end
    end

    // Queue storage: written at the tail on every push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]   <= 32'h0000_0000;
                q_data_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            q_pc_r[wr_ptr_r]   <= resp_pc_r;
            q_data_r[wr_ptr_r] <= imemRespData;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]   <= q_pc_r[i];
                q_data_r[i] <= q_data_r[i];
            end
        end
    end

    assign imemReq  = req_s;
    assign imemAddr = fetch_pc_r;
    assign instr    = instr_r;
    assign PC       = pc_r;
    assign flush    = flush_r;

endmodule
